// File: rtl/tensor_pkg.sv
// Shared types and constants for the tensor dot-product reduction stage.
package tensor_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        REDUCE,
        OUT
    } state_e;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

    // Slot index width; covers the largest legal ADD_LAT of 4.
    localparam int unsigned SLOT_W = 2;

    function automatic bit add_lat_legal(input int unsigned lat);
        return (lat >= 2) && (lat <= 4);
    endfunction

endpackage

// File: rtl/tensor_fp32_add_pipe.sv
// Pipelined FP32 adder (RNE, canonical NaN), fixed latency ADD_LAT, no backpressure.
// A sideband meta word travels alongside each operation.
module tensor_fp32_add_pipe
    import tensor_pkg::*;
#(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned META_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [31:0]       a_i,
    input  logic [31:0]       b_i,
    input  logic [META_W-1:0] meta_i,
    output logic              valid_o,
    output logic [31:0]       sum_o,
    output logic [META_W-1:0] meta_o
);

    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic        sl, ss;
        logic [9:0]  xl, xs, d, ex, sh;
        logic [23:0] fl, fs;
        logic [26:0] ml, ms, msh, m;
        logic [27:0] sum;
        logic [4:0]  lz;
        logic        rup;
        logic [30:0] mag;
        logic [31:0] res;
        sl  = 1'b0;
        ss  = 1'b0;
        xl  = '0;
        xs  = '0;
        fl  = '0;
        fs  = '0;
        ex  = '0;
        sh  = '0;
        m   = '0;
        sum = '0;
        lz  = '0;
        res = FP32_POS_ZERO;
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0)) begin
            res = FP32_QNAN;
        end else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) begin
            res = (a[31] == b[31]) ? a : FP32_QNAN;
        end else if (a[30:23] == 8'hFF) begin
            res = a;
        end else if (b[30:23] == 8'hFF) begin
            res = b;
        end else begin
            // Order operands by magnitude so the difference path never goes negative.
            if (a[30:0] >= b[30:0]) begin
                sl = a[31];
                ss = b[31];
                xl = {2'b0, (a[30:23] == 8'd0) ? 8'd1 : a[30:23]};
                xs = {2'b0, (b[30:23] == 8'd0) ? 8'd1 : b[30:23]};
                fl = {a[30:23] != 8'd0, a[22:0]};
                fs = {b[30:23] != 8'd0, b[22:0]};
            end else begin
                sl = b[31];
                ss = a[31];
                xl = {2'b0, (b[30:23] == 8'd0) ? 8'd1 : b[30:23]};
                xs = {2'b0, (a[30:23] == 8'd0) ? 8'd1 : a[30:23]};
                fl = {b[30:23] != 8'd0, b[22:0]};
                fs = {a[30:23] != 8'd0, a[22:0]};
            end
            ml = {fl, 3'b000};
            ms = {fs, 3'b000};
            d  = xl - xs;
            if (d >= 10'd27) begin
                msh = '0;
                msh[0] = |ms;
            end else begin
                msh = ms >> d;
                msh[0] = msh[0] | (|(ms & ~({27{1'b1}} << d)));
            end
            if (sl == ss) begin
                sum = {1'b0, ml} + {1'b0, msh};
                if (sum[27]) begin
                    m    = sum[27:1];
                    m[0] = m[0] | sum[0];
                    ex   = xl + 10'd1;
                end else begin
                    m  = sum[26:0];
                    ex = xl;
                end
            end else begin
                m  = ml - msh;
                lz = 5'd27;
                for (int i = 0; i < 27; i++) begin
                    if (m[i]) lz = 5'(26 - i);
                end
                sh = ({5'b0, lz} < (xl - 10'd1)) ? {5'b0, lz} : (xl - 10'd1);
                m  = m << sh;
                ex = xl - sh;
            end
            if (m == 27'd0) begin
                res = {(sl == ss) ? sl : 1'b0, 31'd0};
            end else begin
                if (!m[26]) ex = 10'd0;
                if (ex >= 10'd255) begin
                    res = {sl, 8'hFF, 23'd0};
                end else begin
                    rup = m[2] & (m[1] | m[0] | m[3]);
                    mag = {ex[7:0], m[25:3]} + {30'd0, rup};
                    res = {sl, mag};
                end
            end
        end
        return res;
    endfunction

    logic [ADD_LAT-1:0] vld_q;
    logic [31:0]        sum_q  [ADD_LAT];
    logic [META_W-1:0]  meta_q [ADD_LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                sum_q[i]  <= FP32_POS_ZERO;
                meta_q[i] <= '0;
            end
        end else begin
            vld_q     <= {vld_q[ADD_LAT-2:0], valid_i};
            sum_q[0]  <= fp32_add(a_i, b_i);
            meta_q[0] <= meta_i;
            for (int i = 1; i < ADD_LAT; i++) begin
                sum_q[i]  <= sum_q[i-1];
                meta_q[i] <= meta_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[ADD_LAT-1];
    assign sum_o   = sum_q[ADD_LAT-1];
    assign meta_o  = meta_q[ADD_LAT-1];

endmodule

// File: rtl/tensor_dot_accum.sv
// Reduces a stream of FP32 products into one sum per in_last-delimited group,
// interleaving partial sums across ADD_LAT slots to hide adder latency.
module tensor_dot_accum
    import tensor_pkg::*;
#(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned TAGW    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic            in_last,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [TAGW-1:0] out_tag
);

    localparam int unsigned       MetaW   = SLOT_W + 1;
    localparam logic [SLOT_W-1:0] LastPtr = SLOT_W'(ADD_LAT - 1);
    localparam logic [2:0]        LastIdx = 3'(ADD_LAT);

    if (!add_lat_legal(ADD_LAT)) begin : g_bad_lat
        $error("tensor_dot_accum: ADD_LAT must be within 2..4");
    end

    state_e              state_q;
    logic [31:0]         slot_q [ADD_LAT];
    logic [ADD_LAT-1:0]  busy_q, busy_eff, busy_d;
    logic [SLOT_W-1:0]   ptr_q;
    logic [2:0]          rd_idx_q;
    logic                red_first_q;
    logic                alive_q;

    logic                iss_valid;
    logic [31:0]         iss_a, iss_b;
    logic [MetaW-1:0]    iss_meta;
    logic                ret_valid;
    logic [31:0]         ret_data;
    logic [MetaW-1:0]    ret_meta;
    logic                ret_red;
    logic [SLOT_W-1:0]   ret_slot;
    logic                in_hs;

    assign ret_red  = ret_meta[SLOT_W];
    assign ret_slot = ret_meta[SLOT_W-1:0];

    // A slot whose result lands this cycle is free again: this keeps one product per cycle.
    always_comb begin
        busy_eff = busy_q;
        if (ret_valid && !ret_red) busy_eff[ret_slot] = 1'b0;
        busy_d = busy_eff;
        if (in_hs) busy_d[ptr_q] = 1'b1;
    end

    assign in_ready = alive_q && (state_q == ACCUM) && !busy_eff[ptr_q];
    assign in_hs    = in_valid && in_ready;

    always_comb begin
        iss_valid = 1'b0;
        iss_a     = slot_q[ptr_q];
        iss_b     = in_data;
        iss_meta  = {1'b0, ptr_q};
        if (in_hs) begin
            iss_valid = 1'b1;
            if (ret_valid && !ret_red && (ret_slot == ptr_q)) iss_a = ret_data;
        end
        if (state_q == REDUCE) begin
            if (red_first_q) begin
                iss_valid = 1'b1;
                iss_a     = slot_q[0];
                iss_b     = slot_q[1];
                iss_meta  = {1'b1, {SLOT_W{1'b0}}};
            end else if (ret_valid && ret_red && (rd_idx_q != LastIdx)) begin
                iss_valid = 1'b1;
                iss_a     = ret_data;
                iss_b     = slot_q[rd_idx_q[SLOT_W-1:0]];
                iss_meta  = {1'b1, {SLOT_W{1'b0}}};
            end
        end
    end

    tensor_fp32_add_pipe #(
        .ADD_LAT (ADD_LAT),
        .META_W  (MetaW)
    ) u_add (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (iss_valid),
        .a_i     (iss_a),
        .b_i     (iss_b),
        .meta_i  (iss_meta),
        .valid_o (ret_valid),
        .sum_o   (ret_data),
        .meta_o  (ret_meta)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            for (int i = 0; i < ADD_LAT; i++) slot_q[i] <= FP32_POS_ZERO;
            busy_q      <= '0;
            ptr_q       <= '0;
            rd_idx_q    <= '0;
            red_first_q <= 1'b0;
            alive_q     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= FP32_POS_ZERO;
            out_tag     <= '0;
        end else begin
            alive_q <= 1'b1;
            busy_q  <= busy_d;
            if (ret_valid && !ret_red) slot_q[ret_slot] <= ret_data;
            unique case (state_q)
                ACCUM: begin
                    if (in_hs) begin
                        ptr_q <= (ptr_q == LastPtr) ? '0 : ptr_q + 1'b1;
                        if (in_last) begin
                            out_tag <= in_tag;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (busy_eff == '0) begin
                        red_first_q <= 1'b1;
                        state_q     <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (red_first_q) begin
                        red_first_q <= 1'b0;
                        rd_idx_q    <= 3'd2;
                    end else if (ret_valid && ret_red) begin
                        if (rd_idx_q == LastIdx) begin
                            out_data  <= ret_data;
                            out_valid <= 1'b1;
                            state_q   <= OUT;
                        end else begin
                            rd_idx_q <= rd_idx_q + 3'd1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        for (int i = 0; i < ADD_LAT; i++) slot_q[i] <= FP32_POS_ZERO;
                        ptr_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_dot_accum.sv
// Directed bench for tensor_dot_accum (ADD_LAT=2): table of groups plus hand-written sequences.
module tb_tensor_dot_accum;

    localparam int Lat = 6;

    typedef struct packed {
        logic [4:0]        n;
        logic [15:0][31:0] data;
        logic [3:0]        tag;
        logic [31:0]       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;
    int mon_hs = 0;

    tensor_dot_accum #(
        .ADD_LAT (2),
        .TAGW    (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (in_valid && in_ready) mon_hs <= mon_hs + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] int_to_fp(input int k);
        int e;
        logic [31:0] m;
        e = 0;
        for (int i = 0; i < 24; i++) if (k >= (1 << i)) e = i;
        m = 32'(k) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic vec_t mk(input int n, input logic [3:0] tag, input logic [31:0] e,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v = '0;
        v.n = 5'(n);
        v.tag = tag;
        v.exp = e;
        v.data[0] = d0;
        v.data[1] = d1;
        v.data[2] = d2;
        v.data[3] = d3;
        return v;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 of the cycle after the handshake.
    task automatic send(input logic [31:0] d, input logic last, input logic [3:0] tag,
                        output int hs_cyc);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        in_tag = tag;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            guard++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out(output int seen, output int leak);
        int k;
        k = 0;
        leak = 0;
        while (!out_valid && k < 60) begin
            if (in_ready) leak++;
            @(posedge clk);
            #1;
            k++;
        end
        if (in_ready) leak++;
        seen = out_valid ? cyc : -1000;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_tag", 32'(out_tag), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", 32'(in_ready), 32'd1);
    endtask

    // Full group with out_ready=1: latency, data, tag, stall-free and in_ready behaviour.
    task automatic run_group(input string nm, input vec_t v, input bit gaps);
        int hs, seen, leak, st0, hs0;
        st0 = stalls;
        hs0 = mon_hs;
        hs = 0;
        for (int i = 0; i < int'(v.n); i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            send(v.data[i], i == int'(v.n) - 1, v.tag, hs);
        end
        wait_out(seen, leak);
        check({nm, "_latency"}, 32'(seen - hs), 32'(Lat));
        check({nm, "_data"}, out_data, v.exp);
        check({nm, "_tag"}, 32'(out_tag), 32'(v.tag));
        check({nm, "_ready_low"}, 32'(leak), 32'd0);
        check({nm, "_hs_count"}, 32'(mon_hs - hs0), 32'(v.n));
        if (!gaps) check({nm, "_no_stall"}, 32'(stalls - st0), 32'd0);
        @(posedge clk);
        #1;
        check({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({nm, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t tbl [8];
        vec_t v;
        int bad, hs, seen, leak;

        tbl[0] = mk(4, 4'h3, 32'h41200000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        tbl[1] = mk(1, 4'hA, 32'h40B00000, 32'h40B00000, 32'h0, 32'h0, 32'h0);
        tbl[2] = mk(1, 4'h1, 32'h00000000, 32'h80000000, 32'h0, 32'h0, 32'h0);
        tbl[3] = mk(3, 4'h5, 32'h40500000, 32'h3FC00000, 32'hBF000000, 32'h40100000, 32'h0);
        tbl[4] = mk(2, 4'h7, 32'h00000000, 32'h42C80000, 32'hC2C80000, 32'h0, 32'h0);
        tbl[5] = mk(3, 4'h2, 32'h3F600000, 32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h0);
        tbl[6] = mk(2, 4'h9, 32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h0, 32'h0);
        tbl[7] = mk(2, 4'hC, 32'hC0A00000, 32'h40400000, 32'hC1000000, 32'h0, 32'h0);

        do_reset();

        bad = 0;
        repeat (20) begin
            if (out_valid || !in_ready) bad++;
            @(posedge clk);
            #1;
        end
        check("idle", 32'(bad), 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) run_group($sformatf("tbl%0d", i), tbl[i], 1'b0);

        // Backpressure: result must hold while out_ready=0; stray products are ignored.
        out_ready = 1'b0;
        v = '0;
        v.n = 5'd8;
        for (int i = 0; i < 8; i++) v.data[i] = 32'h3F800000;
        for (int i = 0; i < 8; i++) send(v.data[i], i == 7, 4'h6, hs);
        wait_out(seen, leak);
        check("bp_latency", 32'(seen - hs), 32'(Lat));
        bad = 0;
        in_valid = 1'b1;
        in_data = 32'h42C80000;
        in_last = 1'b1;
        repeat (10) begin
            if (!out_valid || out_data !== 32'h41000000 || out_tag !== 4'h6 || in_ready) bad++;
            @(posedge clk);
            #1;
        end
        check("bp_hold", 32'(bad), 32'd0);
        check("bp_data", out_data, 32'h41000000);
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        run_group("bp_next", mk(2, 4'h4, 32'h40800000, 32'h40000000, 32'h40000000, 32'h0, 32'h0),
                  1'b0);

        // Integers 1..16 with random idle gaps.
        v = '0;
        v.n = 5'd16;
        v.tag = 4'hE;
        v.exp = 32'h43080000;
        for (int i = 0; i < 16; i++) v.data[i] = int_to_fp(i + 1);
        run_group("gaps", v, 1'b1);

        // Abort a group with reset, then confirm no residue.
        send(32'h3F800000, 1'b0, 4'h0, hs);
        send(32'h40400000, 1'b0, 4'h0, hs);
        send(32'h41000000, 1'b0, 4'h0, hs);
        do_reset();
        run_group("post_rst", mk(2, 4'h8, 32'h40800000, 32'h40000000, 32'h40000000, 32'h0, 32'h0),
                  1'b0);
        run_group("nan", mk(3, 4'hB, 32'h7FC00000, 32'h3F800000, 32'h7FC12345, 32'h40000000,
                  32'h0), 1'b0);
        run_group("neg_nan", mk(1, 4'hD, 32'h7FC00000, 32'hFFC00001, 32'h0, 32'h0, 32'h0), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tensor_dot_accum.md
Name: tensor_dot_accum

Overview:
- Downstream reduction stage of the tensor FP multiplier.
- Consumes a stream of FP32 products, one per handshake, grouped into dot-products by `in_last`.
- Accumulates each group through a pipelined FP32 adder and emits one FP32 sum per group, with its tag.
- Hides adder latency with ADD_LAT interleaved partial-sum slots, then collapses the slots into one result.

Parameters:
- ADD_LAT, 2: adder pipeline latency in cycles; legal values 2..4.
- TAGW, 4: width of the tag carried from the last product of a group to its result.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  product valid.
- in_ready  out  1  block can accept a product.
- in_data  in  32  FP32 product.
- in_last  in  1  this product closes the current group.
- in_tag  in  TAGW  group tag; sampled only on the in_last handshake.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  FP32 group sum.
- out_tag  out  TAGW  tag of the group.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n).
  - While reset_n=0: state=ACCUM, all slots=+0.0 (32'h0), slot pointer=0, busy bits=0, in_ready=0, out_valid=0, out_data=0, out_tag=0.
  - in_ready rises the first cycle after reset_n deasserts.
  - Reset mid-group discards all partial sums and any in-flight adds.
- Adder model: sub-module issue at cycle t gives a registered result at cycle t+ADD_LAT. Rounding is RNE. A NaN in gives canonical NaN 32'h7FC00000 out.
- ACCUM state:
  - in_ready=1 unless busy[ptr]=1.
  - Handshake: issue slot[ptr]+in_data, set busy[ptr], then ptr=(ptr+1) mod ADD_LAT.
  - Returning result writes its slot and clears busy.
  - Bypass: if a result returns to slot k in the same cycle slot k is issued, the issue uses the returning value.
  - With bypass, back-to-back products sustain one per cycle; no stall is permitted on continuous input.
  - Handshake with in_last=1: capture in_tag, go to DRAIN.
- DRAIN state:
  - in_ready=0.
  - Wait until all busy bits clear, then go to REDUCE.
- REDUCE state:
  - in_ready=0.
  - Issue slot0+slot1; when that result returns, issue acc+slot2, and so on until slot[ADD_LAT-1].
  - The final sum is registered into out_data; go to OUT.
- OUT state:
  - out_valid=1; out_data and out_tag hold stable until out_ready=1.
  - On the out handshake: clear slots to +0.0, ptr=0, go to ACCUM.
  - in_ready stays 0 in OUT, so the next group starts no earlier than the cycle after the out handshake.
- Latency:
  - out_valid rises exactly L = ADD_LAT*ADD_LAT+2 cycles after the in_last handshake cycle; L=6 for ADD_LAT=2.
  - This is independent of group length.
- Single-product group: the result equals that product plus zeros; -0.0 becomes +0.0.
- Summation order: slot-interleaved. Results are bit-exact only for exactly representable sums.
- out_valid never deasserts without a handshake. in_valid while in_ready=0 is ignored, with no state change.

Decomposition:
- Package tensor_pkg:
  - state enum {ACCUM, DRAIN, REDUCE, OUT}.
  - FP32 constants: FP32_POS_ZERO, FP32_QNAN.
  - ADD_LAT legality check function.
- One sub-module, tensor_fp32_add_pipe:
  - Pipelined FP32 adder, latency ADD_LAT, no backpressure.
  - Wraps the FP adder core in ADD mode with the RNE rounding mode.

Test Plan:
1. Reset then idle: in_ready rises 1 cycle after reset_n release; out_valid=0 for 20 cycles with in_valid=0.
2. ADD_LAT=2, back-to-back 1.0,2.0,3.0,4.0 (last on 4.0), out_ready=1 → in_ready never drops; out_data=32'h41200000 (10.0) at exactly 6 cycles after the last handshake.
3. Single product 5.5 with in_last, tag=4'hA → out_data=32'h40B00000, out_tag=4'hA; in_ready=0 until the cycle after the out handshake.
4. Backpressure: group 1.0×8 with out_ready=0 for 10 cycles → out_valid and out_data=32'h41000000 held stable throughout; the next group is accepted only after out_ready rises.
5. Random in_valid gaps (50%) over 16 integer products 1..16 → sum 136.0 (32'h43080000); no product dropped or duplicated; busy stall observed only in non-continuous traffic.
6. reset_n pulsed low mid-group after 3 products, then group 2.0,2.0 → out_data=32'h40800000 (4.0); no residue from the aborted group; a NaN product in a later group gives 32'h7FC00000.
